usb_rcv_ctrl: RTL and testbench

- Receive control unit for the USB full-speed receiver.
- Sequences the NRZI decoder and bit shift register through a packet: SYNC, PID, token or data payload, CRC check, and EOP.
- Drives the per-field shift enables consumed by the decoder and the CRC5/CRC16 checkers.
- Validates the SYNC and PID fields and the CRC residual, and hands payload bytes to the RX FIFO, withholding the two trailing CRC16 bytes.

---
 rtl/usb_rcv_ctrl_pkg.sv | 42 ++++
 rtl/usb_rcv_ctrl_if.sv | 39 +++
 rtl/usb_rcv_ctrl_rcv_byte_delay.sv | 68 ++++++
 rtl/usb_rcv_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_usb_rcv_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_rcv_ctrl_pkg.sv
// Shared types for the USB full-speed receive controller.
// Covers the FSM state encoding, the PID codes and PID classification.
package usb_rcv_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SYNC  = 4'd1,
        PID   = 4'd2,
        TOKEN = 4'd3,
        DATA  = 4'd4,
        HSHK  = 4'd5,
        EOPW  = 4'd6,
        DONE  = 4'd7,
        ERR   = 4'd8
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        PC_TOKEN,
        PC_DATA,
        PC_HSHK,
        PC_INVALID
    } pid_class_t;

    function automatic pid_class_t pid_class(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP:  return PC_TOKEN;
            PID_DATA0, PID_DATA1:        return PC_DATA;
            PID_ACK, PID_NAK, PID_STALL: return PC_HSHK;
            default:                     return PC_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/usb_rcv_ctrl_if.sv
// Bundle between the receive front end (decoder, shifter, CRC checkers) and the controller.
// The FIFO-side signals are carried here as well.
interface usb_rcv_ctrl_if;

    logic       bit_strobe;
    logic       d_edge;
    logic       eop;
    logic [7:0] rcv_byte;
    logic       crc_valid;

    logic       sync_shift_enable;
    logic       pid_shift_enable;
    logic       crc5_shift_enable;
    logic       crc16_shift_enable;
    logic       data_shift_enable;
    logic       crc_clear;
    logic [3:0] pid;
    logic [7:0] data_out;
    logic       data_we;
    logic [6:0] byte_count;
    logic       rcving;
    logic       rcv_done;
    logic       rcv_error;

    modport master (
        output bit_strobe, d_edge, eop, rcv_byte, crc_valid,
        input  sync_shift_enable, pid_shift_enable, crc5_shift_enable,
               crc16_shift_enable, data_shift_enable, crc_clear, pid,
               data_out, data_we, byte_count, rcving, rcv_done, rcv_error
    );

    modport slave (
        input  bit_strobe, d_edge, eop, rcv_byte, crc_valid,
        output sync_shift_enable, pid_shift_enable, crc5_shift_enable,
               crc16_shift_enable, data_shift_enable, crc_clear, pid,
               data_out, data_we, byte_count, rcving, rcv_done, rcv_error
    );

endinterface

// File: rtl/usb_rcv_ctrl_rcv_byte_delay.sv
// Two-byte holding buffer that keeps the trailing CRC16 bytes out of the FIFO.
// A push into a full buffer releases the oldest byte with a one-cycle write strobe.
module rcv_byte_delay (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       flush_i,
    input  logic [7:0] data_i,
    output logic       full_o,
    output logic [7:0] data_o,
    output logic       we_o
);

    logic [7:0] buf0_q, buf0_d;
    logic [7:0] buf1_q, buf1_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       we_q, we_d;

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        we_d   = 1'b0;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else if (push_i) begin
            case (cnt_q)
                2'd0: begin
                    buf0_d = data_i;
                    cnt_d  = 2'd1;
                end
                2'd1: begin
                    buf1_d = data_i;
                    cnt_d  = 2'd2;
                end
                default: begin
                    data_d = buf0_q;
                    we_d   = 1'b1;
                    buf0_d = buf1_q;
                    buf1_d = data_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_q <= 8'h00;
            buf1_q <= 8'h00;
            cnt_q  <= 2'd0;
            data_q <= 8'h00;
            we_q   <= 1'b0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            we_q   <= we_d;
        end
    end

    assign full_o = (cnt_q == 2'd2);
    assign data_o = data_q;
    assign we_o   = we_q;

endmodule

// File: rtl/usb_rcv_ctrl.sv
// USB full-speed receive controller: walks a packet through SYNC, PID, payload and EOP,
// gates the per-field shift enables, and forwards payload bytes to the RX FIFO.
module usb_rcv_ctrl
    import usb_rcv_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'h80,
    parameter int         MAX_DATA_BYTES = 64
) (
    input logic           clk,
    input logic           rst,
    usb_rcv_ctrl_if.slave bus
);

    localparam logic [6:0] RX_LIMIT = 7'(MAX_DATA_BYTES + 2);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [4:0] tok_cnt_q, tok_cnt_d;
    logic [6:0] rx_cnt_q, rx_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic [3:0] pid_q, pid_d;
    logic       crc_clear_q, crc_clear_d;
    logic       rcv_done_q, rcv_done_d;
    logic       rcv_error_q, rcv_error_d;
    logic [6:0] byte_count_q, byte_count_d;

    logic       strobe;
    logic       counting;
    logic       push;
    logic       flush;
    logic       buf_full;
    pid_class_t pclass;

    // eop wins over a coincident strobe, so the strobe is dropped everywhere
    assign strobe   = bus.bit_strobe & ~bus.eop;
    assign counting = (state_q == SYNC) || (state_q == PID) ||
                      (state_q == TOKEN) || (state_q == DATA);
    assign flush    = (state_q != DATA);
    assign pclass   = pid_class(bus.rcv_byte[3:0]);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tok_cnt_d    = tok_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        byte_done_d  = 1'b0;
        pid_d        = pid_q;
        crc_clear_d  = 1'b0;
        rcv_done_d   = 1'b0;
        rcv_error_d  = rcv_error_q;
        byte_count_d = byte_count_q;
        push         = 1'b0;

        if (counting && strobe) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
        end

        case (state_q)
            IDLE: begin
                if (bus.d_edge) begin
                    state_d      = SYNC;
                    rcv_error_d  = 1'b0;
                    byte_count_d = 7'd0;
                    pid_d        = 4'd0;
                    bit_cnt_d    = 3'd0;
                end
            end
            SYNC: begin
                if (bus.eop) begin
                    state_d = ERR;
                end else if (byte_done_q) begin
                    state_d = (bus.rcv_byte == SYNC_BYTE) ? PID : ERR;
                end
            end
            PID: begin
                if (bus.eop) begin
                    state_d = ERR;
                end else if (byte_done_q) begin
                    if (bus.rcv_byte[7:4] != ~bus.rcv_byte[3:0]) begin
                        state_d = ERR;
                    end else begin
                        pid_d       = bus.rcv_byte[3:0];
                        crc_clear_d = 1'b1;
                        tok_cnt_d   = 5'd0;
                        rx_cnt_d    = 7'd0;
                        case (pclass)
                            PC_TOKEN: state_d = TOKEN;
                            PC_DATA:  state_d = DATA;
                            PC_HSHK:  state_d = HSHK;
                            default:  state_d = ERR;
                        endcase
                    end
                end
            end
            TOKEN: begin
                if (bus.eop) begin
                    state_d = ERR;
                end else if (strobe) begin
                    tok_cnt_d = tok_cnt_q + 5'd1;
                    if (tok_cnt_q == 5'd15) begin
                        state_d = EOPW;
                    end
                end
            end
            DATA: begin
                // a byte finishing on the first eop cycle still counts toward the packet
                if (byte_done_q && (rx_cnt_q == RX_LIMIT)) begin
                    state_d = ERR;
                end else begin
                    if (byte_done_q) begin
                        push     = 1'b1;
                        rx_cnt_d = rx_cnt_q + 7'd1;
                    end
                    if (bus.eop) begin
                        if ((bit_cnt_q != 3'd0) || (rx_cnt_d < 7'd2) || !bus.crc_valid) begin
                            state_d = ERR;
                        end else begin
                            state_d    = DONE;
                            rcv_done_d = 1'b1;
                        end
                    end
                end
            end
            HSHK: begin
                if (bus.eop) begin
                    state_d    = DONE;
                    rcv_done_d = 1'b1;
                end else if (bus.bit_strobe) begin
                    state_d = ERR;
                end
            end
            EOPW: begin
                if (bus.eop) begin
                    if (bus.crc_valid) begin
                        state_d    = DONE;
                        rcv_done_d = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end else if (bus.bit_strobe) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                if (!bus.eop) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (bus.eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ERR) begin
            rcv_error_d = 1'b1;
        end
        if (push && buf_full) begin
            byte_count_d = byte_count_q + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            tok_cnt_q    <= 5'd0;
            rx_cnt_q     <= 7'd0;
            byte_done_q  <= 1'b0;
            pid_q        <= 4'd0;
            crc_clear_q  <= 1'b0;
            rcv_done_q   <= 1'b0;
            rcv_error_q  <= 1'b0;
            byte_count_q <= 7'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tok_cnt_q    <= tok_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            byte_done_q  <= byte_done_d;
            pid_q        <= pid_d;
            crc_clear_q  <= crc_clear_d;
            rcv_done_q   <= rcv_done_d;
            rcv_error_q  <= rcv_error_d;
            byte_count_q <= byte_count_d;
        end
    end

    rcv_byte_delay u_byte_delay (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .flush_i (flush),
        .data_i  (bus.rcv_byte),
        .full_o  (buf_full),
        .data_o  (bus.data_out),
        .we_o    (bus.data_we)
    );

    assign bus.sync_shift_enable  = (state_q == SYNC) & strobe;
    assign bus.pid_shift_enable   = (state_q == PID) & strobe;
    assign bus.crc5_shift_enable  = (state_q == TOKEN) & strobe;
    assign bus.crc16_shift_enable = (state_q == DATA) & strobe;
    assign bus.data_shift_enable  = (state_q == DATA) & strobe;
    assign bus.crc_clear          = crc_clear_q;
    assign bus.pid                = pid_q;
    assign bus.byte_count         = byte_count_q;
    assign bus.rcving             = (state_q != IDLE) && (state_q != DONE);
    assign bus.rcv_done           = rcv_done_q;
    assign bus.rcv_error          = rcv_error_q;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Directed bench for usb_rcv_ctrl: drives bit-level packets and checks flags,
// enable pulse counts, and FIFO bytes against a queue of expected payload bytes.
module tb_usb_rcv_ctrl;

    logic clk;
    logic rst;

    usb_rcv_ctrl_if bus ();

    usb_rcv_ctrl #(
        .SYNC_BYTE      (8'h80),
        .MAX_DATA_BYTES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb[$];
    logic [7:0] shiftReg;
    logic [7:0] expByte;

    int crc5Count     = 0;
    int crc16Count    = 0;
    int enableCount   = 0;
    int doneCount     = 0;
    int dataWeCount   = 0;
    int crcClearCount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({bus.sync_shift_enable, bus.pid_shift_enable, bus.crc5_shift_enable,
                    bus.crc16_shift_enable, bus.data_shift_enable, bus.crc_clear, bus.pid,
                    bus.data_out, bus.data_we, bus.byte_count, bus.rcving, bus.rcv_done,
                    bus.rcv_error});
    endfunction

    // Counts enable/strobe pulses and retires FIFO writes against the expected-byte queue
    always @(negedge clk) begin
        if (bus.crc5_shift_enable)  crc5Count++;
        if (bus.crc16_shift_enable) crc16Count++;
        if (bus.sync_shift_enable | bus.pid_shift_enable | bus.crc5_shift_enable |
            bus.crc16_shift_enable | bus.data_shift_enable) enableCount++;
        if (bus.rcv_done)  doneCount++;
        if (bus.crc_clear) crcClearCount++;
        if (bus.data_we) begin
            dataWeCount++;
            checkOutput("sb_has_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                expByte = sb.pop_front();
                checkOutput("data_out", 32'(bus.data_out), 32'(expByte));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One recovered bit: a single-cycle strobe, shift register updated after it
    task automatic applyStimulus(input logic b);
        bus.bit_strobe = 1'b1;
        tick(1);
        bus.bit_strobe = 1'b0;
        shiftReg       = {b, shiftReg[7:1]};
        bus.rcv_byte   = shiftReg;
        tick(2);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) applyStimulus(v[i]);
    endtask

    task automatic startPacket();
        bus.d_edge = 1'b1;
        tick(1);
        bus.d_edge = 1'b0;
        tick(1);
    endtask

    task automatic endPacket(input logic crcOk);
        bus.eop       = 1'b1;
        bus.crc_valid = crcOk;
        tick(3);
        bus.eop       = 1'b0;
        bus.crc_valid = 1'b0;
        tick(3);
    endtask

    initial begin
        int c5, c16, en, dn, we, cc;
        logic [7:0] v;

        rst            = 1'b1;
        bus.bit_strobe = 1'b0;
        bus.d_edge     = 1'b0;
        bus.eop        = 1'b0;
        bus.rcv_byte   = 8'h00;
        bus.crc_valid  = 1'b0;
        shiftReg       = 8'h00;
        tick(3);
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        rst = 1'b0;
        tick(2);
        checkOutput("idle_outputs", allOutputs(), 32'd0);

        $display("[TB] clean OUT token");
        c5 = crc5Count; dn = doneCount; we = dataWeCount; cc = crcClearCount;
        startPacket();
        checkOutput("token_rcving", 32'(bus.rcving), 32'd1);
        sendByte(8'h80);
        sendByte(8'hE1);
        checkOutput("token_pid", 32'(bus.pid), 32'h1);
        checkOutput("token_crc_clear", crcClearCount - cc, 32'd1);
        for (int i = 0; i < 16; i++) applyStimulus(1'($urandom_range(0, 1)));
        checkOutput("token_crc5_pulses", crc5Count - c5, 32'd16);
        endPacket(1'b1);
        checkOutput("token_done_pulses", doneCount - dn, 32'd1);
        checkOutput("token_no_we", dataWeCount - we, 32'd0);
        checkOutput("token_error", 32'(bus.rcv_error), 32'd0);
        checkOutput("token_rcving_after", 32'(bus.rcving), 32'd0);

        $display("[TB] DATA0 with three payload bytes");
        c16 = crc16Count; dn = doneCount; we = dataWeCount;
        startPacket();
        sendByte(8'h80);
        sendByte(8'hC3);
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
        sendByte(8'hA7); sendByte(8'h5C);
        endPacket(1'b1);
        checkOutput("data0_we_pulses", dataWeCount - we, 32'd3);
        checkOutput("data0_byte_count", 32'(bus.byte_count), 32'd3);
        checkOutput("data0_done", doneCount - dn, 32'd1);
        checkOutput("data0_crc16_pulses", crc16Count - c16, 32'd40);
        checkOutput("data0_pid", 32'(bus.pid), 32'h3);
        checkOutput("data0_sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] bad PID check nibble");
        startPacket();
        sendByte(8'h80);
        sendByte(8'hE2);
        checkOutput("badpid_error", 32'(bus.rcv_error), 32'd1);
        en = enableCount;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
        checkOutput("badpid_no_enables", enableCount - en, 32'd0);
        checkOutput("badpid_rcving", 32'(bus.rcving), 32'd1);
        endPacket(1'b1);
        checkOutput("badpid_idle", 32'(bus.rcving), 32'd0);
        checkOutput("badpid_error_held", 32'(bus.rcv_error), 32'd1);
        dn = doneCount;
        startPacket();
        checkOutput("dedge_clears_error", 32'(bus.rcv_error), 32'd0);
        sendByte(8'h80);
        sendByte(8'hD2);
        endPacket(1'b0);
        checkOutput("ack_done_no_crc", doneCount - dn, 32'd1);
        checkOutput("ack_no_error", 32'(bus.rcv_error), 32'd0);

        $display("[TB] DATA1 with bad CRC");
        dn = doneCount; we = dataWeCount;
        startPacket();
        sendByte(8'h80);
        sendByte(8'h4B);
        sb.push_back(8'h55); sb.push_back(8'h66);
        sendByte(8'h55); sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
        endPacket(1'b0);
        checkOutput("data1_we_pulses", dataWeCount - we, 32'd2);
        checkOutput("data1_byte_count", 32'(bus.byte_count), 32'd2);
        checkOutput("data1_error", 32'(bus.rcv_error), 32'd1);
        checkOutput("data1_no_done", doneCount - dn, 32'd0);

        $display("[TB] handshake with trailing bits, then short data byte");
        dn = doneCount; we = dataWeCount;
        startPacket();
        sendByte(8'h80);
        sendByte(8'hD2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        checkOutput("ack_extra_error", 32'(bus.rcv_error), 32'd1);
        endPacket(1'b1);
        checkOutput("ack_extra_no_done", doneCount - dn, 32'd0);
        startPacket();
        sendByte(8'h80);
        sendByte(8'hC3);
        sendByte(8'hAA); sendByte(8'hBB);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1);
        endPacket(1'b1);
        checkOutput("partial_byte_error", 32'(bus.rcv_error), 32'd1);
        checkOutput("partial_byte_no_done", doneCount - dn, 32'd0);
        checkOutput("partial_byte_no_we", dataWeCount - we, 32'd0);

        $display("[TB] payload length limit");
        dn = doneCount; we = dataWeCount;
        startPacket();
        sendByte(8'h80);
        sendByte(8'hC3);
        for (int i = 0; i < 66; i++) begin
            v = 8'(i * 37 + 5);
            if (i < 64) sb.push_back(v);
            sendByte(v);
        end
        checkOutput("limit66_no_error", 32'(bus.rcv_error), 32'd0);
        checkOutput("limit66_byte_count", 32'(bus.byte_count), 32'd64);
        sendByte(8'hEE);
        checkOutput("limit67_error", 32'(bus.rcv_error), 32'd1);
        endPacket(1'b1);
        checkOutput("limit_we_pulses", dataWeCount - we, 32'd64);
        checkOutput("limit_no_done", doneCount - dn, 32'd0);
        checkOutput("limit_sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] reset mid DATA");
        dn = doneCount; we = dataWeCount;
        startPacket();
        sendByte(8'h80);
        sendByte(8'hC3);
        sendByte(8'h5A); sendByte(8'hA5);
        checkOutput("pre_reset_pid", 32'(bus.pid), 32'h3);
        checkOutput("pre_reset_rcving", 32'(bus.rcving), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", allOutputs(), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        checkOutput("post_reset_outputs", allOutputs(), 32'd0);
        checkOutput("reset_no_we", dataWeCount - we, 32'd0);
        checkOutput("reset_no_done", doneCount - dn, 32'd0);
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
